// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   UART receiver for the lidar host/sensor serial links. The frame format is
//   set by parameters: data width 5..8, parity none/even/odd, and 1 or 2 stop
//   bits. Each bit is decided by a 3-sample majority vote around mid-bit. A
//   start bit that is high again at mid-bit is treated as a glitch and dropped.
//   The receiver reports parity, framing, break and overrun conditions.
//   A finished byte is held on a valid/ready handshake until it is accepted.
//
// Parameters
//   CLK_FRE    clock frequency in MHz
//   BAUD_RATE  serial baud rate; CLK_FRE*1e6/BAUD_RATE must be >= 8
//   DATA_BITS  data bits per frame, 5..8
//   PARITY     0 none, 1 even, 2 odd
//   STOP_BITS  1 or 2
//
// Ports
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   rx_pin         serial input, idle high, asynchronous to clk
//   rx_data        received byte, zero-extended above DATA_BITS-1
//   rx_data_valid  rx_data and error flags are valid; held until accepted
//   rx_data_ready  consumer accepts the byte when high with rx_data_valid
//   parity_err     parity mismatch for the held byte
//   frame_err      at least one stop-bit sample of the held byte was 0
//   break_det      1-cycle pulse: all-zero data, parity and first stop bit
//   overrun_err    1-cycle pulse: a frame finished while a byte was still held
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int CLK_FRE   = 40,
    parameter int BAUD_RATE = 460800,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 2,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       break_det,
    output logic       overrun_err
);

    localparam int          CYCLE      = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [15:0] CNT_LAST   = 16'(CYCLE - 1);
    localparam logic [15:0] CNT_MID    = 16'(CYCLE / 2);
    localparam logic [15:0] CNT_MID_M1 = 16'(CYCLE / 2 - 1);
    localparam logic [15:0] CNT_MID_M2 = 16'(CYCLE / 2 - 2);
    localparam logic [2:0]  BIT_LAST   = 3'(DATA_BITS - 1);
    localparam logic        STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic        PARITY_ON  = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Two-out-of-three majority used for the mid-bit vote
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter should have sent for this data word
    function automatic logic expected_parity(input logic [7:0] d);
        logic p;
        if (PARITY == 1) begin
            p = ^d;
        end else begin
            p = ~^d;
        end
        return p;
    endfunction

    logic        sync1_r;
    logic        rxs_r;
    logic        rxs_prev_r;
    logic        start_edge_s;
    logic        vote_s;
    logic        first_stop_zero_s;

    state_t      state_r;
    logic [15:0] cycle_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic        stop_idx_r;
    logic        samp0_r;
    logic        samp1_r;
    logic [7:0]  data_buf_r;
    logic        par_bit_r;
    logic        ferr_acc_r;
    logic        first_stop_zero_r;
    logic        done_r;
    logic        perr_pend_r;
    logic        ferr_pend_r;
    logic        brk_pend_r;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; all idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            sync1_r    <= rx_pin;
            rxs_r      <= sync1_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // Start edge, mid-bit majority vote and the break test on the first stop bit
    always_comb begin
        start_edge_s      = rxs_prev_r & ~rxs_r;
        vote_s            = majority3(samp0_r, samp1_r, rxs_r);
        first_stop_zero_s = first_stop_zero_r;
        if (stop_idx_r == 1'b0) begin
            first_stop_zero_s = ~vote_s;
        end else begin
            first_stop_zero_s = first_stop_zero_r;
        end
    end

    // Frame FSM: bit timing, sampling, data assembly and error accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= ST_IDLE;
            cycle_cnt_r       <= 16'd0;
            bit_cnt_r         <= 3'd0;
            stop_idx_r        <= 1'b0;
            samp0_r           <= 1'b1;
            samp1_r           <= 1'b1;
            data_buf_r        <= 8'h00;
            par_bit_r         <= 1'b0;
            ferr_acc_r        <= 1'b0;
            first_stop_zero_r <= 1'b0;
            done_r            <= 1'b0;
            perr_pend_r       <= 1'b0;
            ferr_pend_r       <= 1'b0;
            brk_pend_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (cycle_cnt_r == CNT_MID_M2) begin
                samp0_r <= rxs_r;
            end
            if (cycle_cnt_r == CNT_MID_M1) begin
                samp1_r <= rxs_r;
            end

            case (state_r)
                ST_IDLE: begin
                    cycle_cnt_r <= 16'd0;
                    // A line held low (e.g. after a break) shows no falling edge, so it cannot restart here
                    if (start_edge_s) begin
                        state_r           <= ST_START;
                        bit_cnt_r         <= 3'd0;
                        stop_idx_r        <= 1'b0;
                        ferr_acc_r        <= 1'b0;
                        first_stop_zero_r <= 1'b0;
                    end
                end

                ST_START: begin
                    if ((cycle_cnt_r == CNT_MID) && vote_s) begin
                        // Line back high at mid start bit: glitch, drop silently
                        state_r     <= ST_IDLE;
                        cycle_cnt_r <= 16'd0;
                    end else if (cycle_cnt_r == CNT_LAST) begin
                        state_r     <= ST_DATA;
                        cycle_cnt_r <= 16'd0;
                    end else begin
                        cycle_cnt_r <= cycle_cnt_r + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (cycle_cnt_r == CNT_MID) begin
                        data_buf_r[bit_cnt_r] <= vote_s;
                    end
                    if (cycle_cnt_r == CNT_LAST) begin
                        cycle_cnt_r <= 16'd0;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= PARITY_ON ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        cycle_cnt_r <= cycle_cnt_r + 16'd1;
                    end
                end

                ST_PARITY: begin
                    if (cycle_cnt_r == CNT_MID) begin
                        par_bit_r <= vote_s;
                    end
                    if (cycle_cnt_r == CNT_LAST) begin
                        state_r     <= ST_STOP;
                        cycle_cnt_r <= 16'd0;
                    end else begin
                        cycle_cnt_r <= cycle_cnt_r + 16'd1;
                    end
                end

                ST_STOP: begin
                    if (cycle_cnt_r == CNT_MID) begin
                        first_stop_zero_r <= first_stop_zero_s;
                        if (stop_idx_r == STOP_LAST) begin
                            // Leave half a bit early so a back-to-back start edge is not missed
                            state_r     <= ST_IDLE;
                            cycle_cnt_r <= 16'd0;
                            done_r      <= 1'b1;
                            ferr_pend_r <= ferr_acc_r | ~vote_s;
                            perr_pend_r <= PARITY_ON && (par_bit_r != expected_parity(data_buf_r));
                            brk_pend_r  <= (data_buf_r == 8'h00) && (!PARITY_ON || !par_bit_r)
                                           && first_stop_zero_s;
                        end else begin
                            ferr_acc_r  <= ferr_acc_r | ~vote_s;
                            cycle_cnt_r <= cycle_cnt_r + 16'd1;
                        end
                    end else if (cycle_cnt_r == CNT_LAST) begin
                        stop_idx_r  <= 1'b1;
                        cycle_cnt_r <= 16'd0;
                    end else begin
                        cycle_cnt_r <= cycle_cnt_r + 16'd1;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    cycle_cnt_r <= 16'd0;
                end
            endcase
        end
    end

    // Completion handshake: deliver the finished frame, or flag an overrun if the previous byte is still held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            break_det     <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
            if (done_r) begin
                break_det <= brk_pend_r;
                // Acceptance in the same cycle frees the slot, so the new byte replaces the old one
                if (!rx_data_valid || rx_data_ready) begin
                    rx_data       <= data_buf_r;
                    parity_err    <= perr_pend_r;
                    frame_err     <= ferr_pend_r;
                    rx_data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end else begin
                rx_data_valid <= rx_data_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_cfg: three instances (8O1, 8E1, 7N2) share one clock/reset.
module tb_uart_rx_cfg;

    localparam int CYC = 86;

    logic       clk;
    logic       rst_n;
    logic [2:0] pin;
    logic [2:0] rdy;
    logic [7:0] dout [3];
    logic       vld  [3];
    logic       pe   [3];
    logic       fe   [3];
    logic       brk  [3];
    logic       ovr  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FRE(40), .BAUD_RATE(460800), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o (
        .clk(clk), .rst_n(rst_n), .rx_pin(pin[0]), .rx_data(dout[0]), .rx_data_valid(vld[0]),
        .rx_data_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .break_det(brk[0]),
        .overrun_err(ovr[0]));

    uart_rx_cfg #(.CLK_FRE(40), .BAUD_RATE(460800), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e (
        .clk(clk), .rst_n(rst_n), .rx_pin(pin[1]), .rx_data(dout[1]), .rx_data_valid(vld[1]),
        .rx_data_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .break_det(brk[1]),
        .overrun_err(ovr[1]));

    uart_rx_cfg #(.CLK_FRE(40), .BAUD_RATE(460800), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7 (
        .clk(clk), .rst_n(rst_n), .rx_pin(pin[2]), .rx_data(dout[2]), .rx_data_valid(vld[2]),
        .rx_data_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .break_det(brk[2]),
        .overrun_err(ovr[2]));

    typedef struct {
        int         id;
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    typedef struct {
        string name;
        int    got;
        int    exp;
    } chk_t;

    exp_t q[$];
    chk_t chk_q[$];
    exp_t mon_e;
    chk_t mon_c;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   brk_cnt [3];
    int   ovr_cnt [3];
    int   brk_base;
    int   ovr_base;

    initial begin
        for (int i = 0; i < 3; i++) begin
            brk_cnt[i] = 0;
            ovr_cnt[i] = 0;
        end
    end

    // Monitor: compares every accepted byte against the scoreboard and every directed check
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (brk[i]) brk_cnt[i]++;
            if (ovr[i]) ovr_cnt[i]++;
            if (vld[i] && rdy[i]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_byte inst=%0d: got data=%02h pe=%0b fe=%0b, none expected",
                             i, dout[i], pe[i], fe[i]);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.id != i || dout[i] != mon_e.d || pe[i] != mon_e.p || fe[i] != mon_e.f) begin
                        n_bad++;
                        $display("FAIL frame inst=%0d: got data=%02h pe=%0b fe=%0b, expected inst=%0d data=%02h pe=%0b fe=%0b",
                                 i, dout[i], pe[i], fe[i], mon_e.id, mon_e.d, mon_e.p, mon_e.f);
                    end
                end
            end
        end
        while (chk_q.size() != 0) begin
            mon_c = chk_q.pop_front();
            n_cmp++;
            if (mon_c.got != mon_c.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h, expected %0h", mon_c.name, mon_c.got, mon_c.exp);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        chk_t c;
        c.name = name;
        c.got  = got;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_byte(input int id, input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.id = id;
        e.d  = d;
        e.p  = p;
        e.f  = f;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int id, input logic b);
        pin[id] = b;
        repeat (CYC) @(posedge clk);
        #1;
    endtask

    // One frame: start, data LSB first, optional parity, one or two stop bits, then idle high
    task automatic send(input int id, input logic [7:0] d, input int nd, input int pm, input logic pb,
                        input logic s1, input logic s2, input int ns);
        drive_bit(id, 1'b0);
        for (int i = 0; i < nd; i++) drive_bit(id, d[i]);
        if (pm != 0) drive_bit(id, pb);
        drive_bit(id, s1);
        if (ns == 2) drive_bit(id, s2);
        pin[id] = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, q.size(), 0);
        if (q.size() != 0) q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        pin   = 3'b111;
        rdy   = 3'b111;
        idle(4);
        for (int i = 0; i < 3; i++) begin
            check("reset_outputs", int'({dout[i], vld[i], pe[i], fe[i], brk[i], ovr[i]}), 0);
        end
        rst_n = 1'b1;
        idle(10);

        // 8E1 0xA5 with correct even parity 0, consumer initially not ready
        rdy[1] = 1'b0;
        expect_byte(1, 8'hA5, 1'b0, 1'b0);
        send(1, 8'hA5, 8, 1, 1'b0, 1'b1, 1'b1, 1);
        check("e_valid_held", int'(vld[1]), 1);
        rdy[1] = 1'b1;
        @(posedge clk);
        #1;
        check("e_valid_clear", int'(vld[1]), 0);
        wait_drain("drain_a5");
        idle(10);

        // 8O1 0x3C with wrong parity bit 0
        expect_byte(0, 8'h3C, 1'b1, 1'b0);
        send(0, 8'h3C, 8, 2, 1'b0, 1'b1, 1'b1, 1);
        wait_drain("drain_3c");
        idle(10);

        // 8O1 0x55, correct parity, stop bit low
        expect_byte(0, 8'h55, 1'b0, 1'b1);
        send(0, 8'h55, 8, 2, 1'b1, 1'b0, 1'b1, 1);
        wait_drain("drain_55");
        idle(10);

        // Break: line low for 12 bit times; odd parity of 0x00 expects 1, so parity also flagged
        brk_base = brk_cnt[0];
        expect_byte(0, 8'h00, 1'b1, 1'b1);
        pin[0] = 1'b0;
        repeat (12 * CYC) @(posedge clk);
        #1;
        check("break_no_restart_low", int'(vld[0]), 0);
        pin[0] = 1'b1;
        idle(300);
        check("break_pulses", brk_cnt[0] - brk_base, 1);
        check("break_no_second", int'(vld[0]), 0);
        wait_drain("drain_break");

        // Start glitch: 20 clocks low
        pin[0] = 1'b0;
        idle(20);
        pin[0] = 1'b1;
        idle(300);
        check("glitch_no_valid", int'(vld[0]), 0);

        // Overrun: consumer stalled over two frames, second byte is dropped
        ovr_base = ovr_cnt[0];
        rdy[0] = 1'b0;
        expect_byte(0, 8'h11, 1'b0, 1'b0);
        send(0, 8'h11, 8, 2, 1'b1, 1'b1, 1'b1, 1);
        idle(20);
        send(0, 8'h22, 8, 2, 1'b1, 1'b1, 1'b1, 1);
        idle(5);
        check("overrun_pulses", ovr_cnt[0] - ovr_base, 1);
        check("overrun_keeps_old", int'(dout[0]), 8'h11);
        check("overrun_valid_held", int'(vld[0]), 1);
        rdy[0] = 1'b1;
        wait_drain("drain_overrun");
        idle(10);

        // Ready raised exactly in the completion cycle of the second frame
        ovr_base = ovr_cnt[0];
        rdy[0] = 1'b0;
        expect_byte(0, 8'h11, 1'b0, 1'b0);
        expect_byte(0, 8'h22, 1'b0, 1'b0);
        send(0, 8'h11, 8, 2, 1'b1, 1'b1, 1'b1, 1);
        idle(20);
        fork
            send(0, 8'h22, 8, 2, 1'b1, 1'b1, 1'b1, 1);
            begin
                repeat (907) @(posedge clk);
                #1;
                rdy[0] = 1'b1;
            end
        join
        idle(3);
        check("coincide_no_overrun", ovr_cnt[0] - ovr_base, 0);
        wait_drain("drain_coincide");
        idle(10);

        // 7N2: clean 0x7F, then second stop bit low
        expect_byte(2, 8'h7F, 1'b0, 1'b0);
        send(2, 8'h7F, 7, 0, 1'b0, 1'b1, 1'b1, 2);
        wait_drain("drain_7f");
        idle(10);
        expect_byte(2, 8'h7F, 1'b0, 1'b1);
        send(2, 8'h7F, 7, 0, 1'b0, 1'b1, 1'b0, 2);
        wait_drain("drain_7f_stop2");
        idle(10);

        // Reset during data bit 4, then a clean frame
        fork
            send(0, 8'h5A, 8, 2, 1'b1, 1'b1, 1'b1, 1);
            begin
                repeat (5 * CYC + 40) @(posedge clk);
                #1;
                rst_n = 1'b0;
            end
        join
        check("midreset_outputs", int'({dout[0], vld[0], pe[0], fe[0], brk[0], ovr[0]}), 0);
        idle(5);
        rst_n = 1'b1;
        idle(10);
        check("midreset_no_valid", int'(vld[0]), 0);
        expect_byte(0, 8'h96, 1'b0, 1'b0);
        send(0, 8'h96, 8, 2, 1'b1, 1'b1, 1'b1, 1);
        wait_drain("drain_96");

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
